// File: rtl/spi_burst_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_burst_ctrl : feeds spi_master a multi-byte continuous-mode burst from a
//                  TX FIFO and collects the returned bytes into an RX FIFO.
// Revision: 1.0
// ---------------------------------------------------------------------------
module spi_burst_ctrl #(
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        slave_sel,
  input  logic [LEN_W-1:0]   len,
  input  logic               tx_wr,
  input  logic [D_WIDTH-1:0] tx_wdata,
  output logic               tx_full,
  output logic [LEN_W:0]     tx_level,
  input  logic               rx_rd,
  output logic [D_WIDTH-1:0] rx_rdata,
  output logic               rx_empty,
  output logic [LEN_W:0]     rx_level,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               spi_enable,
  output logic               spi_cont,
  output logic [31:0]        spi_addr,
  output logic [D_WIDTH-1:0] spi_tx_data,
  input  logic               spi_busy,
  input  logic [D_WIDTH-1:0] spi_rx_data
);

  localparam int c_AW  = $clog2(DEPTH);
  localparam int c_LW1 = LEN_W + 1;
  localparam logic [LEN_W:0] c_DEPTH_L = c_LW1'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_XFER   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]         r_state;
  logic               r_busy_q;
  logic [LEN_W-1:0]   r_len, r_sent, r_rcvd;
  logic [31:0]        r_addr;
  logic [D_WIDTH-1:0] r_tx_data;
  logic               r_cont, r_en, r_done, r_err;

  logic [D_WIDTH-1:0] r_tx_mem [DEPTH];
  logic [c_AW-1:0]    r_tx_wptr, r_tx_rptr;
  logic [LEN_W:0]     r_tx_level;
  logic [D_WIDTH-1:0] r_rx_mem [DEPTH];
  logic [c_AW-1:0]    r_rx_wptr, r_rx_rptr;
  logic [LEN_W:0]     r_rx_level;
  logic [D_WIDTH-1:0] r_rx_rdata;

  logic               w_rise, w_fall, w_bad;
  logic               w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic               w_tx_pop_req, w_tx_pop, w_tx_push;
  logic               w_rx_pop, w_rx_push;
  logic [LEN_W:0]     w_len_x;
  logic [D_WIDTH-1:0] w_tx_head;

  assign w_rise     = spi_busy & ~r_busy_q;
  assign w_fall     = ~spi_busy & r_busy_q;
  assign w_tx_full  = (r_tx_level == c_DEPTH_L);
  assign w_tx_empty = (r_tx_level == '0);
  assign w_rx_full  = (r_rx_level == c_DEPTH_L);
  assign w_rx_empty = (r_rx_level == '0);
  assign w_tx_head  = r_tx_mem[r_tx_rptr];

  assign w_len_x = {1'b0, len};
  assign w_bad   = (len == '0) | (w_len_x > c_DEPTH_L) | (r_tx_level < w_len_x) |
                   ((c_DEPTH_L - r_rx_level) < w_len_x);

  assign w_tx_pop_req = ((r_state == S_LAUNCH) & ~spi_busy) |
                        ((r_state == S_XFER) & w_rise & (r_sent < r_len));
  assign w_tx_pop     = w_tx_pop_req & ~w_tx_empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign w_tx_push    = tx_wr & (~w_tx_full | w_tx_pop);
  assign w_rx_pop     = rx_rd & ~w_rx_empty;
  assign w_rx_push    = (r_state == S_XFER) & w_fall & (~w_rx_full | w_rx_pop);

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= spi_rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_level <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_level <= '0;
      r_rx_rdata <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_level <= r_tx_level + c_LW1'(1);
        2'b01:   r_tx_level <= r_tx_level - c_LW1'(1);
        default: r_tx_level <= r_tx_level;
      endcase
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop) begin
        r_rx_rptr  <= r_rx_rptr + 1'b1;
        r_rx_rdata <= r_rx_mem[r_rx_rptr];
      end
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_level <= r_rx_level + c_LW1'(1);
        2'b01:   r_rx_level <= r_rx_level - c_LW1'(1);
        default: r_rx_level <= r_rx_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy_q  <= 1'b1;
      r_len     <= '0;
      r_sent    <= '0;
      r_rcvd    <= '0;
      r_addr    <= '0;
      r_tx_data <= '0;
      r_cont    <= 1'b0;
      r_en      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_busy_q <= spi_busy;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_len   <= len;
              r_addr  <= slave_sel;
              r_sent  <= '0;
              r_rcvd  <= '0;
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (!spi_busy) begin
            r_tx_data <= w_tx_head;
            r_cont    <= (r_len > LEN_W'(1));
            r_en      <= 1'b1;
            r_sent    <= LEN_W'(1);
            r_state   <= S_XFER;
          end
        end
        S_XFER: begin
          // Each rise starts a byte; cont stays high unless this is the final byte.
          if (w_rise) begin
            r_en   <= 1'b0;
            r_cont <= (r_sent < r_len);
            if (r_sent < r_len) begin
              r_tx_data <= w_tx_head;
              r_sent    <= r_sent + LEN_W'(1);
            end
          end
          if (w_fall) begin
            r_rcvd <= r_rcvd + LEN_W'(1);
            if (r_rcvd + LEN_W'(1) == r_len) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_cont  <= 1'b0;
          r_en    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_full     = w_tx_full;
  assign tx_level    = r_tx_level;
  assign rx_rdata    = r_rx_rdata;
  assign rx_empty    = w_rx_empty;
  assign rx_level    = r_rx_level;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;
  assign spi_enable  = r_en;
  assign spi_cont    = r_cont;
  assign spi_addr    = r_addr;
  assign spi_tx_data = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_burst_ctrl : directed bench with a loopback spi_master model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_spi_burst_ctrl;
  localparam int D_WIDTH   = 8;
  localparam int DEPTH     = 16;
  localparam int LEN_W     = 5;
  localparam int BYTE_CLKS = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [31:0]        slave_sel = '0;
  logic [LEN_W-1:0]   len = '0;
  logic               tx_wr = 1'b0;
  logic [D_WIDTH-1:0] tx_wdata = '0;
  logic               tx_full;
  logic [LEN_W:0]     tx_level;
  logic               rx_rd = 1'b0;
  logic [D_WIDTH-1:0] rx_rdata;
  logic               rx_empty;
  logic [LEN_W:0]     rx_level;
  logic               busy, done, err;
  logic               spi_enable, spi_cont;
  logic [31:0]        spi_addr;
  logic [D_WIDTH-1:0] spi_tx_data;
  logic               spi_busy;
  logic [D_WIDTH-1:0] spi_rx_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_burst_ctrl #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .slave_sel(slave_sel), .len(len),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_level(tx_level),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_level(rx_level),
    .busy(busy), .done(done), .err(err),
    .spi_enable(spi_enable), .spi_cont(spi_cont), .spi_addr(spi_addr),
    .spi_tx_data(spi_tx_data), .spi_busy(spi_busy), .spi_rx_data(spi_rx_data)
  );

  // spi_master stand-in: fixed-length bytes, one idle clock between
  // continuous bytes, MISO looped back to MOSI.
  logic       m_busy, m_gap;
  int         m_cnt;
  logic [7:0] m_sh, m_rx;
  int         m_starts = 0;
  int         m_ends = 0;
  logic [7:0] m_wire [256];
  logic       m_cont_log [256];

  assign spi_busy    = m_busy;
  assign spi_rx_data = m_rx;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_gap  <= 1'b0;
      m_cnt  <= 0;
      m_rx   <= '0;
    end else if (!m_busy) begin
      if (m_gap || spi_enable) begin
        m_gap  <= 1'b0;
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_sh   <= spi_tx_data;
        if (m_starts < 256) m_wire[m_starts] <= spi_tx_data;
        m_starts <= m_starts + 1;
      end
    end else if (m_cnt == BYTE_CLKS - 1) begin
      m_busy <= 1'b0;
      m_rx   <= m_sh;
      m_gap  <= spi_cont;
      if (m_ends < 256) m_cont_log[m_ends] <= spi_cont;
      m_ends <= m_ends + 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  int done_cnt = 0;
  int err_cnt = 0;
  int en_cnt = 0;
  always @(negedge clk) begin
    if (done)       done_cnt <= done_cnt + 1;
    if (err)        err_cnt  <= err_cnt + 1;
    if (spi_enable) en_cnt   <= en_cnt + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic push(input logic [7:0] b);
    tx_wr = 1'b1;
    tx_wdata = b;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic pop(output logic [7:0] d);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    d = rx_rdata;
  endtask

  task automatic pulse_start(input logic [31:0] sel, input int n);
    slave_sel = sel;
    len = LEN_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: done=0 required done=1 within 2000 clk", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, err, spi_enable, spi_cont, tx_full, rx_empty} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_flags: got busy,done,err,en,cont,full,empty=%b required 0000001",
               {busy, done, err, spi_enable, spi_cont, tx_full, rx_empty});
    end
    checks++;
    if (tx_level !== '0 || rx_level !== '0 || spi_addr !== '0) begin
      errors++;
      $display("FAIL reset_levels: got tx=%0d rx=%0d addr=%h required 0 0 0", tx_level, rx_level, spi_addr);
    end
  endtask

  task automatic test_single();
    int d0, e0, en0;
    logic [7:0] d;
    d0 = done_cnt;
    e0 = m_ends;
    push(8'hA5);
    pulse_start(32'd2, 1);
    en0 = spi_enable;
    checks++;
    if (en0 !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_launch: got en=%0d busy=%b one clk after start required 0 1", en0, busy);
    end
    tick(1);
    checks++;
    if (spi_enable !== 1'b1 || spi_cont !== 1'b0) begin
      errors++;
      $display("FAIL single_enable: got en=%b cont=%b two clk after start required 1 0", spi_enable, spi_cont);
    end
    wait_done("single");
    tick(3);
    checks++;
    if (spi_addr !== 32'd2) begin
      errors++;
      $display("FAIL single_addr: got %h required 00000002", spi_addr);
    end
    checks++;
    if (m_ends - e0 !== 1 || m_cont_log[e0] !== 1'b0) begin
      errors++;
      $display("FAIL single_cont: got bytes=%0d cont=%b required 1 0", m_ends - e0, m_cont_log[e0]);
    end
    checks++;
    if (done_cnt - d0 !== 1 || rx_level !== 6'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done=%0d rx_level=%0d busy=%b required 1 1 0", done_cnt - d0, rx_level, busy);
    end
    pop(d);
    checks++;
    if (d !== 8'hA5 || rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_rx: got %h empty=%b required a5 1", d, rx_empty);
    end
  endtask

  task automatic test_burst4();
    int d0, e0, s0;
    logic [3:0] cl;
    logic [7:0] d;
    bit ok;
    d0 = done_cnt;
    e0 = m_ends;
    s0 = m_starts;
    for (int i = 1; i <= 4; i++) push(8'(i));
    pulse_start(32'd5, 4);
    wait_done("burst4");
    tick(3);
    for (int i = 0; i < 4; i++) cl[i] = m_cont_log[e0 + i];
    checks++;
    if (m_ends - e0 !== 4 || cl !== 4'b0111) begin
      errors++;
      $display("FAIL burst4_cont: got falls=%0d cont(b3..b0)=%b required 4 0111", m_ends - e0, cl);
    end
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (m_wire[s0 + i] !== 8'(i + 1)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL burst4_wire: got %h %h %h %h required 01 02 03 04",
               m_wire[s0], m_wire[s0 + 1], m_wire[s0 + 2], m_wire[s0 + 3]);
    end
    checks++;
    if (done_cnt - d0 !== 1 || rx_level !== 6'd4) begin
      errors++;
      $display("FAIL burst4_done: got done=%0d rx_level=%0d required 1 4", done_cnt - d0, rx_level);
    end
    for (int i = 1; i <= 4; i++) begin
      pop(d);
      checks++;
      if (d !== 8'(i)) begin
        errors++;
        $display("FAIL burst4_rx%0d: got %h required %h", i, d, 8'(i));
      end
    end
  endtask

  task automatic test_reject();
    int r0, n0;
    do_reset();
    push(8'h11);
    push(8'h22);
    r0 = err_cnt;
    n0 = en_cnt;
    pulse_start(32'd1, 3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reject_busy: got busy=%b required 0", busy);
      end
      tick(1);
    end
    checks++;
    if (err_cnt - r0 !== 1 || en_cnt - n0 !== 0) begin
      errors++;
      $display("FAIL reject_short: got err=%0d en=%0d required 1 0", err_cnt - r0, en_cnt - n0);
    end
    pulse_start(32'd1, 0);
    tick(2);
    pulse_start(32'd1, 17);
    tick(3);
    checks++;
    if (err_cnt - r0 !== 3 || en_cnt - n0 !== 0 || tx_level !== 6'd2) begin
      errors++;
      $display("FAIL reject_len: got err=%0d en=%0d tx_level=%0d required 3 0 2",
               err_cnt - r0, en_cnt - n0, tx_level);
    end
  endtask

  task automatic test_rx_space();
    int r0;
    logic [7:0] d;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 15; i++) push(8'h10 + 8'(i));
    pulse_start(32'd3, 15);
    wait_done("fill");
    tick(2);
    push(8'hE0);
    push(8'hE1);
    r0 = err_cnt;
    pulse_start(32'd3, 2);
    tick(3);
    checks++;
    if (err_cnt - r0 !== 1 || rx_level !== 6'd15 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rxspace_reject: got err=%0d rx_level=%0d busy=%b required 1 15 0",
               err_cnt - r0, rx_level, busy);
    end
    pop(d);
    pulse_start(32'd3, 2);
    wait_done("rxspace");
    tick(2);
    checks++;
    if (err_cnt - r0 !== 1 || rx_level !== 6'd16) begin
      errors++;
      $display("FAIL rxspace_retry: got err=%0d rx_level=%0d required 1 16", err_cnt - r0, rx_level);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 14) ? 8'h11 + 8'(i) : 8'hE0 + 8'(i - 14);
      pop(d);
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL rxspace_order%0d: got %h required %h", i, d, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    bit hit;
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    d0 = done_cnt;
    e0 = m_ends;
    pulse_start(32'd7, 4);
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (m_ends - e0 >= 2) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midrst_wait: got bytes=%0d required 2 within 500 clk", m_ends - e0);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (busy !== 1'b0 || tx_level !== '0 || rx_level !== '0 || spi_enable !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got busy=%b tx=%0d rx=%0d en=%b required 0 0 0 0",
               busy, tx_level, rx_level, spi_enable);
    end
    rst = 1'b0;
    tick(20);
    checks++;
    if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_done: got done=%0d busy=%b required 0 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_stream();
    int d0, got;
    bit pend, seen;
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    checks++;
    if (tx_full !== 1'b1 || tx_level !== 6'd16) begin
      errors++;
      $display("FAIL stream_full: got full=%b level=%0d required 1 16", tx_full, tx_level);
    end
    d0 = done_cnt;
    pulse_start(32'd9, 16);
    rx_rd = 1'b1;
    tx_wr = 1'b1;
    got = 0;
    pend = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      tx_wdata = 8'hC0 + 8'(c);
      @(negedge clk);
      if (pend) begin
        checks++;
        if (got >= 16 || rx_rdata !== 8'h40 + 8'(got)) begin
          errors++;
          $display("FAIL stream_rx%0d: got %h required %h", got, rx_rdata, 8'h40 + 8'(got));
        end
        got++;
      end
      pend = !rx_empty;
      if (done) seen = 1'b1;
      if (seen && got >= 16) break;
    end
    rx_rd = 1'b0;
    tx_wr = 1'b0;
    tick(3);
    checks++;
    if (got !== 16 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL stream_count: got bytes=%0d done=%0d required 16 1", got, done_cnt - d0);
    end
    checks++;
    if (rx_level !== '0 || tx_level !== 6'd16 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_levels: got rx=%0d tx=%0d busy=%b required 0 16 0", rx_level, tx_level, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_reject();
    test_rx_space();
    test_reset_mid();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
